// File: rtl/output_row_writer.sv
// Packs the serial convolution result stream into MSB-first row words and writes
// a per-frame dimension header, one word per row, and a terminator to output SRAM.
//
// state | meaning
// IDLE  | no frame active; waiting for frame_start
// ROW   | collecting pixels of the current output row
// WAITF | all rows of the frame written; next frame_start or all_done
// TERM  | terminator write presented; pointer rewinds on exit
module output_row_writer #(
    parameter int              DATA_W        = 16,
    parameter int              ADDR_W        = 12,
    parameter logic [ADDR_W-1:0] OUT_BASE_ADDR = 12'h000,
    parameter logic [DATA_W-1:0] END_MARKER    = 16'h00FF
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              frame_start,
    input  logic [7:0]        out_nrows,
    input  logic [7:0]        out_ncols,
    input  logic              pix_valid,
    input  logic              pix_bit,
    input  logic              row_end,
    input  logic              all_done,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              dut_sram_write_enable,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int COL_W = $clog2(DATA_W + 1);
    localparam int IDX_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, ROW, WAITF, TERM} state_t;

    state_t              state_q, state_d;
    logic [7:0]          nrows_q, nrows_d, ncols_q, ncols_d, row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d, col_pix;
    logic [DATA_W-1:0]   acc_q, acc_d, acc_pix;
    logic [ADDR_W-1:0]   ptr_q, ptr_d, addr_d;
    logic [DATA_W-1:0]   data_d;
    logic                we_d, busy_d, done_d, err_d;
    logic [IDX_W-1:0]    idx;

    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            state_q                <= IDLE;
            nrows_q                <= '0;
            ncols_q                <= '0;
            row_q                  <= '0;
            col_q                  <= '0;
            acc_q                  <= '0;
            ptr_q                  <= OUT_BASE_ADDR;
            dut_sram_write_enable  <= 1'b0;
            dut_sram_write_address <= OUT_BASE_ADDR;
            dut_sram_write_data    <= '0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            err                    <= 1'b0;
        end else begin
            state_q                <= state_d;
            nrows_q                <= nrows_d;
            ncols_q                <= ncols_d;
            row_q                  <= row_d;
            col_q                  <= col_d;
            acc_q                  <= acc_d;
            ptr_q                  <= ptr_d;
            dut_sram_write_enable  <= we_d;
            dut_sram_write_address <= addr_d;
            dut_sram_write_data    <= data_d;
            busy                   <= busy_d;
            done                   <= done_d;
            err                    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        nrows_d = nrows_q;
        ncols_d = ncols_q;
        row_d   = row_q;
        col_d   = col_q;
        acc_d   = acc_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        addr_d  = dut_sram_write_address;
        data_d  = dut_sram_write_data;
        busy_d  = busy;
        done_d  = 1'b0;
        err_d   = err;
        acc_pix = acc_q;
        col_pix = col_q;
        idx     = IDX_W'(DATA_W - 1) - IDX_W'(col_q);

        case (state_q)
            IDLE, WAITF: begin
                if (state_q == IDLE && (pix_valid || row_end || all_done))
                    err_d = 1'b1;
                if (state_q == WAITF && (pix_valid || row_end || (all_done && frame_start)))
                    err_d = 1'b1;
                if (frame_start) begin
                    // header write; pointer keeps running across frames
                    nrows_d = out_nrows;
                    ncols_d = out_ncols;
                    row_d   = '0;
                    col_d   = '0;
                    acc_d   = '0;
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    data_d  = DATA_W'({out_nrows, out_ncols});
                    ptr_d   = ptr_q + ADDR_W'(1);
                    busy_d  = 1'b1;
                    state_d = ROW;
                end else if (state_q == WAITF && all_done) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    data_d  = END_MARKER;
                    done_d  = 1'b1;
                    state_d = TERM;
                end
            end
            ROW: begin
                if (frame_start || all_done)
                    err_d = 1'b1;
                if (pix_valid) begin
                    if (8'(col_q) < ncols_q) begin
                        acc_pix[idx] = pix_bit;
                        col_pix      = col_q + COL_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                acc_d = acc_pix;
                col_d = col_pix;
                if (row_end) begin
                    // same-cycle pixel is already folded into acc_pix
                    we_d   = 1'b1;
                    addr_d = ptr_q;
                    data_d = acc_pix;
                    ptr_d  = ptr_q + ADDR_W'(1);
                    acc_d  = '0;
                    col_d  = '0;
                    if (8'(col_pix) < ncols_q)
                        err_d = 1'b1;
                    row_d = row_q + 8'd1;
                    if (row_q + 8'd1 == nrows_q)
                        state_d = WAITF;
                end
            end
            TERM: begin
                ptr_d   = OUT_BASE_ADDR;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/output_row_writer.md
Name: output_row_writer

Overview:
- Write-side counterpart to the convolution controller's input-read sequencing.
- Takes the serial stream of binary convolution results (one bit per output column) from the conv datapath and packs each output row MSB-first into a 16-bit word.
- Writes a dimension header word per frame, one word per row, and a 16'h00FF terminator after the last frame to output SRAM through the dut_sram_write_* port.
- Owns the output write address pointer. The controller only pulses framing strobes.

Parameters:
DATA_W, 16, output SRAM word width; also the maximum row length in pixels.
ADDR_W, 12, output SRAM address width.
OUT_BASE_ADDR, 12'h000, first output address after reset or after a terminator.
END_MARKER, 16'h00FF, terminator word.

Ports:
clk  in  1  clock; all logic on posedge.
reset_b  in  1  asynchronous, active-high reset (name kept per codebase; asserted = 1).
frame_start  in  1  one-cycle pulse; latch dimensions and begin a frame.
out_nrows  in  8  output rows in the frame; sampled on frame_start; legal 1..255.
out_ncols  in  8  output columns; sampled on frame_start; legal 1..DATA_W.
pix_valid  in  1  pix_bit is valid this cycle.
pix_bit  in  1  convolution result bit.
row_end  in  1  pulse; current row is complete (may coincide with the last pix_valid).
all_done  in  1  pulse; no more frames; emit terminator.
dut_sram_write_address  out  ADDR_W  registered write address.
dut_sram_write_data  out  DATA_W  registered write data.
dut_sram_write_enable  out  1  registered write strobe, one cycle per word.
busy  out  1  high from accepted frame_start until terminator written.
done  out  1  one-cycle pulse in the cycle the terminator write is presented.
err  out  1  sticky protocol error; cleared only by reset.

Behaviour:
- Reset (async, reset_b=1) values:
  - dut_sram_write_enable=0, dut_sram_write_address=OUT_BASE_ADDR, dut_sram_write_data=0.
  - busy=0, done=0, err=0.
  - State IDLE; pointer=OUT_BASE_ADDR; accumulator, col and row counters = 0.
- Reset mid-frame discards the partial row with no write.
- FSM states: IDLE, ROW, WAITF, TERM.
  - IDLE + frame_start → ROW:
    - Latch nrows and ncols.
    - Next cycle: we=1, addr=ptr, data={out_nrows, out_ncols}; ptr+1.
    - busy=1.
  - ROW, pix_valid:
    - Accumulator bit (DATA_W-1-col) = pix_bit; col+1.
    - If col already = ncols: bit dropped, err=1.
  - ROW, row_end:
    - Next cycle: we=1, addr=ptr, data=accumulator including any same-cycle pixel; unfilled LSBs = 0; ptr+1.
    - Accumulator and col cleared on the same edge.
    - row+1. If the new row = nrows → WAITF; else stay ROW.
    - A row_end with col < ncols still writes (zero padded) and sets err=1.
  - WAITF:
    - frame_start → ROW, behaving as in IDLE. The pointer continues, not reset.
    - all_done → TERM.
  - TERM (one cycle):
    - we=1, addr=ptr, data=END_MARKER; done=1.
    - On exit: ptr=OUT_BASE_ADDR, busy=0, → IDLE.
- Latency: exactly 1 cycle from strobe to write. At most one write per cycle. we is low in all other cycles.
- Ignored inputs, each sets err=1 with no other effect:
  - Any input other than frame_start while in IDLE.
  - pix_valid or row_end in WAITF.
  - frame_start or all_done while in ROW.
  - frame_start together with row_end (row_end wins, frame_start dropped).
  - all_done in the same cycle as frame_start in WAITF (frame_start wins).
- Pointer wraps modulo 2^ADDR_W silently.
- data holds its last value when we=0.

Test Plan:
- Single frame: nrows=2, ncols=3; bits 1,0,1 then row_end; bits 1,1,1 with row_end on the third bit; all_done → writes 0x0203@0, 0xA000@1, 0xE000@2, 0x00FF@3, in 4 separate cycles each 1 cycle after its strobe; done coincides with the @3 write; busy falls after it.
- Two back-to-back frames: (1 row, ncols=16, all ones) then (1 row, ncols=1, bit 0), then all_done → 0x0110@0, 0xFFFF@1, 0x0101@2, 0x0000@3, 0x00FF@4; next frame_start writes its header at addr 0.
- Short row: ncols=4, 2 bits (1,1) then row_end → data 0xC000, err=1.
- Overlong row: ncols=2, 3 bits all 1 → data 0xC000, err=1.
- Protocol errors: pix_valid in IDLE → no write, err=1. row_end in WAITF → no write, err=1.
- Reset mid-row: assert reset_b after 2 pixels, release, run a 1×1 frame → header lands at 0x000; no stale bits in the row word.
